// File: rtl/shift_pkg.sv
// shift_pkg: constants and state type shared by the shift_rx deserializer.
`default_nettype none

package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    DATA = 1'b0,
    PAR  = 1'b1
  } rx_state_t;

  // Required XOR of data bits plus parity bit (0 = even parity).
  localparam logic PARITY_EVEN = 1'b0;

endpackage

`default_nettype wire

// File: rtl/rx_bit_counter.sv
// rx_bit_counter: modulo counter with enable, synchronous clear and terminal-count flag.
`default_nettype none

module rx_bit_counter #(
  parameter int MODULUS = 8,
  parameter int CW      = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic clk,
  input  logic areset_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [CW-1:0] count;

  assign tc = (count == CW'(MODULUS - 1));

  // A clear that coincides with an enable counts that bit as the first one.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= en ? CW'(1) : '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_rx.sv
// shift_rx: LSB-first serial-to-parallel receiver with valid/ready output and overrun flag.
// Optional even-parity frame check enabled by defining SHIFT_RX_PARITY_EN.
`default_nettype none

module shift_rx
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             par_err
);

  rx_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             take;
  logic             tc;
  logic             complete;
  logic             pfail;

  // Data bits are only shifted in DATA; a sync restarts a word even from PAR.
  assign take    = sin_valid & ((state == DATA) | sync);
  assign shifted = {sin, shreg[WIDTH-1:1]};

  rx_bit_counter #(
    .MODULUS(WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .areset_n(areset_n),
    .en      (take),
    .clr     (sync),
    .tc      (tc)
  );

  always_comb begin
    complete = 1'b0;
    pfail    = 1'b0;
    word     = shifted;
`ifdef SHIFT_RX_PARITY_EN
    if (sin_valid && !sync && state == PAR) begin
      word = shreg;
      if (((^shreg) ^ sin) == PARITY_EVEN) complete = 1'b1;
      else                                 pfail    = 1'b1;
    end
`else
    complete = sin_valid & ~sync & tc;
`endif
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state   <= DATA;
      shreg   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (take) shreg <= shifted;

      if (sync) begin
        state <= DATA;
`ifdef SHIFT_RX_PARITY_EN
      end else if (state == DATA && sin_valid && tc) begin
        state <= PAR;
      end else if (state == PAR && sin_valid) begin
        state <= DATA;
`endif
      end

      par_err <= pfail;

      if (complete) begin
        if (!q_valid || q_ready) begin
          q       <= word;
          q_valid <= 1'b1;
        end
      end else if (q_valid && q_ready) begin
        q_valid <= 1'b0;
      end

      // A dropped word takes priority over a clear on the same edge.
      if (complete && q_valid && !q_ready) overrun <= 1'b1;
      else if (ovr_clr)                    overrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_rx.sv
// tb_shift_rx: directed vector table plus hand sequences for shift_rx (WIDTH=8).
`default_nettype none

module tb_shift_rx;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       sin, sin_valid, sync, q_ready, ovr_clr;
  logic [7:0] q;
  logic       q_valid, overrun, par_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       sv;
    logic       s;
    logic       sy;
    logic       rdy;
    logic       clr;
    logic [7:0] eq;
    logic       eqv;
    logic       eovr;
  } vec_t;

  vec_t vecs[$];

  shift_rx #(.WIDTH(8)) dut (
    .clk      (clk),
    .areset_n (areset_n),
    .sin      (sin),
    .sin_valid(sin_valid),
    .sync     (sync),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic sv, input logic s, input logic sy, input logic rdy, input logic clr);
    sin_valid = sv; sin = s; sync = sy; q_ready = rdy; ovr_clr = clr;
    @(posedge clk);
    #1;
    sin_valid = 1'b0; sync = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  function automatic void add(input logic sv, input logic s, input logic rdy,
                              input logic [7:0] eq, input logic eqv, input logic eovr);
    vec_t v;
    v.sv = sv; v.s = s; v.sy = 1'b0; v.rdy = rdy; v.clr = 1'b0;
    v.eq = eq; v.eqv = eqv; v.eovr = eovr;
    vecs.push_back(v);
  endfunction

  initial begin
    int early;
    logic [7:0] d3c, dc3;
    d3c = 8'h3C;
    dc3 = 8'hC3;

    // Word A5 (LSB first 1,0,1,0,0,1,0,1) with a 3-cycle gap after bit 4.
    add(1, 1, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0);
    add(1, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'hA5, 1, 0);
    add(0, 0, 1, 8'hA5, 0, 0);
    // 3C then C3 back to back; C3 completes on the same edge 3C is consumed.
    for (int i = 0; i < 8; i++)
      add(1, d3c[i], 0, (i == 7) ? 8'h3C : 8'hA5, (i == 7), 0);
    for (int i = 0; i < 8; i++)
      add(1, dc3[i], (i == 7), (i == 7) ? 8'hC3 : 8'h3C, 1, 0);
    add(0, 0, 1, 8'hC3, 0, 0);

    sin = 0; sin_valid = 0; sync = 0; q_ready = 0; ovr_clr = 0;
    areset_n = 1'b0;
    #12;
    check("reset_q", q, 8'h00);
    check("reset_qv", q_valid, 1'b0);
    check("reset_ovr", overrun, 1'b0);
    check("reset_perr", par_err, 1'b0);
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].sv, vecs[i].s, vecs[i].sy, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_q", i), q, vecs[i].eq);
      check($sformatf("vec%0d_qv", i), q_valid, vecs[i].eqv);
      check($sformatf("vec%0d_ovr", i), overrun, vecs[i].eovr);
    end

    // Overrun: 22 arrives while 11 is unconsumed.
    send_bits(8'h11, 8, 1'b0);
    check("ovr_first_q", q, 8'h11);
    check("ovr_first_qv", q_valid, 1'b1);
    send_bits(8'h22, 8, 1'b0);
    check("ovr_hold_q", q, 8'h11);
    check("ovr_set", overrun, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_clr", overrun, 1'b0);
    check("ovr_consume_qv", q_valid, 1'b0);
    check("ovr_consume_q", q, 8'h11);

    // Alignment: 5 stray bits, sync carrying bit 0 = 0, then seven 1s.
    early = 0;
    send_bits(8'h1F, 5, 1'b0);
    if (q_valid) early++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    if (q_valid) early++;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      if (q_valid) early++;
    end
    check("sync_no_early_valid", early, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sync_q", q, 8'hFE);
    check("sync_qv", q_valid, 1'b1);

    // Asynchronous reset mid-word, away from any clock edge.
    send_bits(8'h0F, 4, 1'b0);
    #2;
    areset_n = 1'b0;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_qv", q_valid, 1'b0);
    check("arst_ovr", overrun, 1'b0);
    @(negedge clk);
    areset_n = 1'b1;
    @(posedge clk);
    #1;
    send_bits(8'h5A, 7, 1'b0);
    check("arst_partial_qv", q_valid, 1'b0);
    send_bits(8'h00, 1, 1'b0);
    check("arst_next_q", q, 8'h5A);
    check("arst_next_qv", q_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SHIFT_RX_PARITY_EN
    send_bits(8'hA5, 8, 1'b0);
    check("par_wait_qv", q_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_ok_q", q, 8'hA5);
    check("par_ok_qv", q_valid, 1'b1);
    check("par_ok_err", par_err, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_bits(8'hA5, 8, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_bad_qv", q_valid, 1'b0);
    check("par_bad_err", par_err, 1'b1);
    check("par_bad_ovr", overrun, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("par_err_pulse", par_err, 1'b0);
`else
    check("par_err_tied", par_err, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
